// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared control encodings plus the stall-controller constants derived from them.
// Constants only; no logic, no latency.
`ifndef CTRL_ENCODE_DEF_V
`define CTRL_ENCODE_DEF_V
`define BRANCH_NONE    2'b00
`define BRANCH_BEQ     2'b01
`define BRANCH_BNE     2'b10
`define JUMP_NONE      2'b00
`define JUMP_J         2'b01
`define JUMP_JAL       2'b10
`define JUMP_REG       2'b11
`define REGSRC_ALU     2'b00
`define REGSRC_DMEM    2'b01
`define REGSRC_PCPLUS4 2'b10
`define HZ_CNT_W       32
`endif

package hazard_stall_ctrl_pkg;
  localparam logic [1:0] BRANCH_NONE    = `BRANCH_NONE;
  localparam logic [1:0] BRANCH_BEQ     = `BRANCH_BEQ;
  localparam logic [1:0] BRANCH_BNE     = `BRANCH_BNE;
  localparam logic [1:0] JUMP_NONE      = `JUMP_NONE;
  localparam logic [1:0] JUMP_J         = `JUMP_J;
  localparam logic [1:0] JUMP_JAL       = `JUMP_JAL;
  localparam logic [1:0] JUMP_REG       = `JUMP_REG;
  localparam logic [1:0] REGSRC_ALU     = `REGSRC_ALU;
  localparam logic [1:0] REGSRC_DMEM    = `REGSRC_DMEM;
  localparam logic [1:0] REGSRC_PCPLUS4 = `REGSRC_PCPLUS4;
  localparam int         HZ_CNT_W       = `HZ_CNT_W;
endpackage

// File: rtl/hazard_shadow_entry.sv
// One shadow pipeline slot {valid, reg_write, reg_src, write_reg}; updates one cycle after load.
// A bubble request clears only the valid bit; the other fields are don't-care when invalid.
module hazard_shadow_entry #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic             next_valid,
  input  logic             next_reg_write,
  input  logic [1:0]       next_reg_src,
  input  logic [RF_AW-1:0] next_write_reg,
  output logic             valid,
  output logic             reg_write,
  output logic [1:0]       reg_src,
  output logic [RF_AW-1:0] write_reg
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
      reg_src   <= 2'b00;
      write_reg <= '0;
    end else if (load) begin
      valid     <= next_valid & ~bubble;
      reg_write <= next_reg_write;
      reg_src   <= next_reg_src;
      write_reg <= next_write_reg;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stalls PC/IF-ID and bubbles ID/EX when the bypass network cannot supply an ID operand.
// Stall decision is combinational (zero latency); shadow EX/MEM state and the counter update per clock.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = HZ_CNT_W,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [RF_AW-1:0] ID_rs,
  input  logic [RF_AW-1:0] ID_rt,
  input  logic             ID_useRs,
  input  logic             ID_useRt,
  input  logic [1:0]       ID_Branch,
  input  logic [1:0]       ID_Jump,
  input  logic             ID_RegWrite,
  input  logic [1:0]       ID_RegSrc,
  input  logic [RF_AW-1:0] ID_WriteReg,
  input  logic             flush,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_bubble,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             ex_valid, ex_reg_write;
  logic [1:0]       ex_reg_src;
  logic [RF_AW-1:0] ex_write_reg;
  logic             mem_valid, mem_reg_write;
  logic [1:0]       mem_reg_src;
  logic [RF_AW-1:0] mem_write_reg;

  hazard_shadow_entry #(.RF_AW(RF_AW)) u_ex_shadow (
    .clk            (clk),
    .rst            (rst),
    .load           (1'b1),
    .bubble         (IDEX_bubble),
    .next_valid     (1'b1),
    .next_reg_write (ID_RegWrite),
    .next_reg_src   (ID_RegSrc),
    .next_write_reg (ID_WriteReg),
    .valid          (ex_valid),
    .reg_write      (ex_reg_write),
    .reg_src        (ex_reg_src),
    .write_reg      (ex_write_reg)
  );

  hazard_shadow_entry #(.RF_AW(RF_AW)) u_mem_shadow (
    .clk            (clk),
    .rst            (rst),
    .load           (1'b1),
    .bubble         (1'b0),
    .next_valid     (ex_valid),
    .next_reg_write (ex_reg_write),
    .next_reg_src   (ex_reg_src),
    .next_write_reg (ex_write_reg),
    .valid          (mem_valid),
    .reg_write      (mem_reg_write),
    .reg_src        (mem_reg_src),
    .write_reg      (mem_write_reg)
  );

  logic ex_prod, mem_prod;
  logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
  logic use_at_id, branch_hazard, load_use_hazard;

  // Register 0 is hardwired, so it never forms a producer/consumer pair.
  assign ex_prod      = ex_valid & ex_reg_write & (ex_write_reg != '0);
  assign mem_prod     = mem_valid & mem_reg_write & (mem_write_reg != '0);
  assign ex_match_rs  = ex_prod & (ex_write_reg == ID_rs);
  assign ex_match_rt  = ex_prod & (ex_write_reg == ID_rt);
  assign mem_match_rs = mem_prod & (mem_write_reg == ID_rs);
  assign mem_match_rt = mem_prod & (mem_write_reg == ID_rt);

  assign use_at_id = (ID_Branch != BRANCH_NONE) | (ID_Jump == JUMP_REG);

  // ID-resolved consumers can take EX results only from PC+4, and MEM results except loads.
  assign branch_hazard = use_at_id &
      (((ex_match_rs | ex_match_rt) &
        ((ex_reg_src == REGSRC_ALU) | (ex_reg_src == REGSRC_DMEM))) |
       ((mem_match_rs | mem_match_rt) & (mem_reg_src == REGSRC_DMEM)));

  assign load_use_hazard = (ex_reg_src == REGSRC_DMEM) &
      ((ex_match_rs & ID_useRs) | (ex_match_rt & ID_useRt));

  assign stall       = ID_valid & ~flush & (branch_hazard | load_use_hazard);
  assign PC_write    = ~stall;
  assign IFID_write  = ~stall;
  assign IDEX_bubble = stall | flush | ~ID_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven vectors plus a saturation sequence; expectations flow through a scoreboard queue.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ID_valid, ID_useRs, ID_useRt, ID_RegWrite, flush;
  logic [4:0] ID_rs, ID_rt, ID_WriteReg;
  logic [1:0] ID_Branch, ID_Jump, ID_RegSrc;
  logic       PC_write, IFID_write, IDEX_bubble, stall;
  logic [31:0] stall_cycles;
  logic       s_pc_write, s_ifid_write, s_idex_bubble, s_stall;
  logic [3:0] s_stall_cycles;

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_useRs(ID_useRs), .ID_useRt(ID_useRt), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_RegWrite(ID_RegWrite), .ID_RegSrc(ID_RegSrc), .ID_WriteReg(ID_WriteReg),
    .flush(flush), .PC_write(PC_write), .IFID_write(IFID_write),
    .IDEX_bubble(IDEX_bubble), .stall(stall), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_useRs(ID_useRs), .ID_useRt(ID_useRt), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_RegWrite(ID_RegWrite), .ID_RegSrc(ID_RegSrc), .ID_WriteReg(ID_WriteReg),
    .flush(flush), .PC_write(s_pc_write), .IFID_write(s_ifid_write),
    .IDEX_bubble(s_idex_bubble), .stall(s_stall), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic       rst, valid, use_rs, use_rt, rw, flush;
    logic [4:0] rs, rt, wr;
    logic [1:0] br, jmp, src;
    logic       e_stall, e_bub;
    int         e_cnt;
  } vec_t;

  typedef struct {
    string      tag;
    logic       s, b;
    logic [31:0] c;
    logic [3:0] cs;
    bit         chk_sat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t ins(logic valid, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic [1:0] br, logic [1:0] jmp, logic rw, logic [1:0] src,
                               logic [4:0] wr);
    vec_t v;
    v.rst = 1'b0; v.flush = 1'b0; v.valid = valid;
    v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
    v.br = br; v.jmp = jmp; v.rw = rw; v.src = src; v.wr = wr;
    v.e_stall = 1'b0; v.e_bub = 1'b0; v.e_cnt = 0;
    return v;
  endfunction

  function automatic vec_t nop();              return ins(0, 0, 0, 0, 0, BRANCH_NONE, JUMP_NONE, 0, REGSRC_ALU, 0); endfunction
  function automatic vec_t lw(logic [4:0] r);  return ins(1, 0, 0, 0, 0, BRANCH_NONE, JUMP_NONE, 1, REGSRC_DMEM, r); endfunction
  function automatic vec_t addi(logic [4:0] r); return ins(1, 0, 0, 1, 0, BRANCH_NONE, JUMP_NONE, 1, REGSRC_ALU, r); endfunction
  function automatic vec_t add(logic [4:0] a, logic [4:0] b); return ins(1, a, b, 1, 1, BRANCH_NONE, JUMP_NONE, 1, REGSRC_ALU, 10); endfunction
  function automatic vec_t beq(logic [4:0] a, logic [4:0] b); return ins(1, a, b, 0, 0, BRANCH_BEQ, JUMP_NONE, 0, REGSRC_ALU, 0); endfunction
  function automatic vec_t bne(logic [4:0] a); return ins(1, a, 0, 0, 0, BRANCH_BNE, JUMP_NONE, 0, REGSRC_ALU, 0); endfunction
  function automatic vec_t jal();              return ins(1, 0, 0, 0, 0, BRANCH_NONE, JUMP_JAL, 1, REGSRC_PCPLUS4, 31); endfunction
  function automatic vec_t jr(logic [4:0] a);  return ins(1, a, 0, 0, 0, BRANCH_NONE, JUMP_REG, 0, REGSRC_ALU, 0); endfunction

  task automatic add_v(vec_t v, bit r, bit f, bit s, bit b, int c);
    v.rst = r; v.flush = f; v.e_stall = s; v.e_bub = b; v.e_cnt = c;
    tbl.push_back(v);
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; flush = v.flush; ID_valid = v.valid;
    ID_rs = v.rs; ID_rt = v.rt; ID_useRs = v.use_rs; ID_useRt = v.use_rt;
    ID_Branch = v.br; ID_Jump = v.jmp; ID_RegWrite = v.rw;
    ID_RegSrc = v.src; ID_WriteReg = v.wr;
  endtask

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (stall !== e.s) begin
      miscompares++; $display("FAIL %s stall: got %b want %b", e.tag, stall, e.s);
    end
    if (PC_write !== ~e.s || IFID_write !== ~e.s) begin
      miscompares++;
      $display("FAIL %s PC_write/IFID_write: got %b/%b want %b", e.tag, PC_write, IFID_write, ~e.s);
    end
    if (IDEX_bubble !== e.b) begin
      miscompares++; $display("FAIL %s IDEX_bubble: got %b want %b", e.tag, IDEX_bubble, e.b);
    end
    if (stall_cycles !== e.c) begin
      miscompares++; $display("FAIL %s stall_cycles: got %0d want %0d", e.tag, stall_cycles, e.c);
    end
    if (e.chk_sat && s_stall_cycles !== e.cs) begin
      miscompares++; $display("FAIL %s sat stall_cycles: got %0d want %0d", e.tag, s_stall_cycles, e.cs);
    end
  endtask

  task automatic apply(vec_t v, string tag, bit chk_sat, logic [3:0] cs);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.tag = tag; e.s = v.e_stall; e.b = v.e_bub; e.c = 32'(v.e_cnt);
    e.cs = cs; e.chk_sat = chk_sat;
    sb.push_back(e);
    #2;
    check_one();
  endtask

  initial begin
    vec_t v;
    drive(nop());
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //      vector        rst flush stall bub cnt
    add_v(nop(),          1, 0, 0, 1, 0);
    add_v(lw(8),          0, 0, 0, 0, 0);   // load-use
    add_v(add(8, 9),      0, 0, 1, 1, 0);
    add_v(add(8, 9),      0, 0, 0, 0, 1);
    add_v(lw(8),          0, 0, 0, 0, 1);   // load then branch: two stalls
    add_v(beq(8, 9),      0, 0, 1, 1, 1);
    add_v(beq(8, 9),      0, 0, 1, 1, 2);
    add_v(beq(8, 9),      0, 0, 0, 0, 3);
    add_v(addi(5),        0, 0, 0, 0, 3);   // ALU producer then branch
    add_v(bne(5),         0, 0, 1, 1, 3);
    add_v(bne(5),         0, 0, 0, 0, 4);
    add_v(jal(),          0, 0, 0, 0, 4);   // PC+4 producer never stalls
    add_v(jr(31),         0, 0, 0, 0, 4);
    add_v(jr(31),         0, 0, 0, 0, 4);
    add_v(lw(0),          0, 0, 0, 0, 4);   // register 0
    add_v(beq(0, 0),      0, 0, 0, 0, 4);
    add_v(beq(0, 0),      0, 0, 0, 0, 4);
    add_v(lw(8),          0, 0, 0, 0, 4);   // flush beats hazard
    add_v(add(8, 9),      0, 1, 0, 1, 4);
    add_v(beq(8, 9),      0, 0, 1, 1, 4);
    add_v(lw(8),          0, 0, 0, 0, 5);   // invalid ID never stalls
    v = add(8, 9); v.valid = 1'b0;
    add_v(v,              0, 0, 0, 1, 5);
    add_v(nop(),          0, 0, 0, 1, 5);
    add_v(lw(8),          0, 0, 0, 0, 5);   // reset during first branch stall
    add_v(beq(8, 9),      1, 0, 1, 1, 5);
    add_v(beq(8, 9),      0, 0, 0, 0, 0);
    add_v(lw(9),          0, 0, 0, 0, 0);   // rt load-use
    add_v(add(3, 9),      0, 0, 1, 1, 0);
    add_v(add(3, 9),      0, 0, 0, 0, 1);
    add_v(lw(9),          0, 0, 0, 0, 1);   // rt matches but not read
    add_v(ins(1, 3, 9, 1, 0, BRANCH_NONE, JUMP_NONE, 1, REGSRC_ALU, 11), 0, 0, 0, 0, 1);
    add_v(nop(),          0, 0, 0, 1, 1);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i), 1'b0, 4'd0);

    // Saturation: 20 load-use stalls on both counters.
    @(negedge clk);
    v = nop(); v.rst = 1'b1;
    drive(v);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] sat;
      sat = (k > 15) ? 4'd15 : 4'(k);
      v = lw(8);  v.e_stall = 1'b0; v.e_bub = 1'b0; v.e_cnt = k;
      apply(v, $sformatf("sat_lw%0d", k), 1'b1, sat);
      v = add(8, 9); v.e_stall = 1'b1; v.e_bub = 1'b1; v.e_cnt = k;
      apply(v, $sformatf("sat_add%0d", k), 1'b1, sat);
    end
    v = nop(); v.e_stall = 1'b0; v.e_bub = 1'b1; v.e_cnt = 20;
    apply(v, "sat_end", 1'b1, 4'd15);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
